// File: rtl/ebus_pkg.sv
// rtl/ebus_pkg.sv - EBUS symbol constants and FSM state encoding shared by transmitter and receiver
package ebus_pkg;

  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] SYM_START = 2'b11;
  localparam logic [1:0] SYM_ACK   = 2'b01;
  localparam logic [1:0] SYM_NAK   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SEND  = 3'd2,
    ST_TURN  = 3'd3,
    ST_ACK   = 3'd4
  } ebus_state_t;

  // Beat 0 carries the most significant bit pair.
  function automatic logic [1:0] beat_sym(input logic [7:0] data, input logic [1:0] beat);
    logic [1:0] sym;
    case (beat)
      2'd0:    sym = data[7:6];
      2'd1:    sym = data[5:4];
      2'd2:    sym = data[3:2];
      default: sym = data[1:0];
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/ebus_iobuf.sv
// rtl/ebus_iobuf.sv - 2-bit tri-state pad driver with input readback
module ebus_iobuf (
  input  logic [1:0] dout,
  input  logic       oe,
  output logic [1:0] din,
  inout  wire  [1:0] pad
);

  assign pad = oe ? dout : 2'bzz;
  assign din = pad;

endmodule

// File: rtl/ebus_tx.sv
// rtl/ebus_tx.sv - EBUS byte transmitter: START, four 2-bit data beats, bus turnaround, ACK/NAK wait
module ebus_tx
  import ebus_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  inout  wire  [1:0] e
);

  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  ebus_state_t state;
  logic [7:0]  data_q;
  logic [1:0]  beat_q;
  logic [7:0]  wait_q;
  logic [1:0]  drv_sym;
  logic        drv_oe;
  logic [1:0]  e_in;

  ebus_iobuf u_io (
    .dout (drv_sym),
    .oe   (drv_oe),
    .din  (e_in),
    .pad  (e)
  );

  // Combinational so the byte can be offered on the very first cycle after reset releases.
  assign tx_ready = (state == ST_IDLE) && !rst;

  // Bus drive (drv_sym/drv_oe) is registered alongside the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      data_q  <= 8'h00;
      beat_q  <= 2'd0;
      wait_q  <= 8'd0;
      done    <= 1'b0;
      ack_ok  <= 1'b0;
      err     <= 1'b0;
      drv_sym <= SYM_IDLE;
      drv_oe  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            data_q  <= tx_data;
            state   <= ST_START;
            drv_sym <= SYM_START;
            drv_oe  <= 1'b1;
          end
        end
        ST_START: begin
          state   <= ST_SEND;
          beat_q  <= 2'd0;
          drv_sym <= beat_sym(data_q, 2'd0);
        end
        ST_SEND: begin
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state   <= ST_TURN;
            drv_oe  <= 1'b0;
            drv_sym <= SYM_IDLE;
          end else begin
            drv_sym <= beat_sym(data_q, beat_q + 2'd1);
          end
        end
        ST_TURN: begin
          state  <= ST_ACK;
          wait_q <= 8'd0;
        end
        ST_ACK: begin
          // A real reply wins over the timeout landing on the same sample.
          if (e_in == SYM_ACK || e_in == SYM_NAK) begin
            state   <= ST_IDLE;
            done    <= 1'b1;
            ack_ok  <= (e_in == SYM_ACK);
            err     <= (e_in == SYM_NAK);
            wait_q  <= 8'd0;
            drv_sym <= SYM_IDLE;
            drv_oe  <= 1'b1;
          end else if (wait_q == WAIT_LAST) begin
            state   <= ST_IDLE;
            done    <= 1'b1;
            ack_ok  <= 1'b0;
            err     <= 1'b1;
            wait_q  <= 8'd0;
            drv_sym <= SYM_IDLE;
            drv_oe  <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          drv_sym <= SYM_IDLE;
          drv_oe  <= 1'b1;
        end
      endcase
    end
  end

endmodule
